// File: rtl/pdp8_clkrst.sv
// Clock divider, stretched system reset and button front-end for the PDP-8 core.
// Define CLKRST_DEBOUNCE_EN to enable per-button debounce counters.

module pdp8_clkrst_btn #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic nReset,
  input  logic tick,
  input  logic nBut,
  output logic but,
  output logic butPress
);
  logic [1:0] sync_pipe;
  logic       sync_b;
  logic       but_nxt;

  // Two-flop synchroniser; idles high like an unpressed active-low button.
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) sync_pipe <= 2'b11;
    else         sync_pipe <= {sync_pipe[0], nBut};

  assign sync_b = ~sync_pipe[1];

`ifdef CLKRST_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          cnt_done;

  assign cnt_done = (cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or negedge nReset)
    if (!nReset) cnt <= '0;
    else if (tick) begin
      if (sync_b == but || cnt_done) cnt <= '0;
      else                           cnt <= cnt + CW'(1);
    end

  assign but_nxt = (sync_b != but && cnt_done) ? sync_b : but;
`else
  assign but_nxt = sync_b;
`endif

  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      but      <= 1'b0;
      butPress <= 1'b0;
    end else if (tick) begin
      but      <= but_nxt;
      butPress <= but_nxt & ~but;
    end
endmodule

module pdp8_clkrst #(
  parameter int DIV        = 4,
  parameter int RST_CYCLES = 16,
  parameter int NBUT       = 2,
  parameter int DEB_CYCLES = 250000,
  parameter int RST_BUT    = -1
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic [NBUT-1:0] nBut,
  output logic            clkOut,
  output logic            clkEn,
  output logic            sysReset,
  output logic [NBUT-1:0] but,
  output logic [NBUT-1:0] butPress
);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [DCW-1:0] div_cnt, div_nxt;
  logic [RCW-1:0] rst_cnt;
  logic           rst_req;

  assign div_nxt = (div_cnt == DCW'(DIV - 1)) ? '0 : div_cnt + DCW'(1);

  // Outputs registered from the next count so clkOut rises on the wrap edge.
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      div_cnt <= '0;
      clkOut  <= 1'b0;
      clkEn   <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      clkOut  <= (div_nxt < DCW'(DIV - DIV / 2));
      clkEn   <= (div_nxt == DCW'(DIV - 1));
    end

  generate
    if (RST_BUT >= 0) begin : g_rst_but
      assign rst_req = but[RST_BUT];
    end else begin : g_no_rst_but
      assign rst_req = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      sysReset <= 1'b1;
      rst_cnt  <= '0;
    end else if (clkEn) begin
      if (rst_req) begin
        sysReset <= 1'b1;
        rst_cnt  <= '0;
      end else if (sysReset) begin
        if (rst_cnt == RCW'(RST_CYCLES - 1)) sysReset <= 1'b0;
        else                                  rst_cnt  <= rst_cnt + RCW'(1);
      end
    end

  pdp8_clkrst_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn [NBUT-1:0] (
    .clk      (clk),
    .nReset   (nReset),
    .tick     (clkEn),
    .nBut     (nBut),
    .but      (but),
    .butPress (butPress)
  );
endmodule
